// File: rtl/voting_pkg.sv
// Shared types and helpers for the voting machine datapath.
// Holds the conditioner FSM state encoding, the candidate count and
// the one-hot test that the vote-logging logic also relies on.
package voting_pkg;

    localparam int NUM_CANDIDATES = 4;

    typedef enum logic [2:0] {
        REL_DEB,
        IDLE,
        PRESS_DEB,
        DECIDE,
        HOLD
    } state_t;

    // True when exactly one candidate bit is set.
    function automatic logic is_onehot(input logic [NUM_CANDIDATES-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            ones = ones + int'(v[i]);
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, WIDTH bits wide.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronised out).
// Latency: q follows d two rising edges later; both stages clear on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ballot_input_conditioner.sv
// Ballot front end: synchronises and debounces the vote button and candidate
// switches, then emits one vote_valid or vote_reject strobe per physical press.
// Ports: clk, reset (sync, active-high), button_raw, candidate_raw, mode in;
//        vote_valid, vote_candidate (held one-hot), vote_reject, busy out.
module ballot_input_conditioner
    import voting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      button_raw,
    input  logic [NUM_CANDIDATES-1:0] candidate_raw,
    input  logic                      mode,
    output logic                      vote_valid,
    output logic [NUM_CANDIDATES-1:0] vote_candidate,
    output logic                      vote_reject,
    output logic                      busy
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic                      s_btn;
    logic [NUM_CANDIDATES-1:0] s_cand;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          deb_cnt;
    logic [CNT_W-1:0]          cnt_next;
    logic [CNT_W-1:0]          cnt_inc;

    logic                      valid_next;
    logic                      reject_next;
    logic [NUM_CANDIDATES-1:0] cand_next;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk   (clk),
        .reset (reset),
        .d     (button_raw),
        .q     (s_btn)
    );

    sync_2ff #(.WIDTH(NUM_CANDIDATES)) u_sync_cand (
        .clk   (clk),
        .reset (reset),
        .d     (candidate_raw),
        .q     (s_cand)
    );

    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc = (deb_cnt == CNT_MAX) ? deb_cnt : deb_cnt + CNT_ONE;

    // ------------------------------------------------------------------
    // State register. Reset lands in REL_DEB so a button held through
    // reset has to be seen released before any press can be accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= REL_DEB;
            deb_cnt <= '0;
        end else begin
            state   <= state_next;
            deb_cnt <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = deb_cnt;
        case (state)
            REL_DEB: begin
                if (s_btn) begin
                    // Release bounce: restart the stable-low count.
                    cnt_next = '0;
                end else if (deb_cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            IDLE: begin
                if (s_btn) begin
                    state_next = PRESS_DEB;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            PRESS_DEB: begin
                if (!s_btn) begin
                    // Too short to be a press: discard as a glitch.
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (deb_cnt == CNT_LAST) begin
                    state_next = DECIDE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            DECIDE: begin
                state_next = HOLD;
                cnt_next   = '0;
            end
            HOLD: begin
                // No auto-repeat: stay here for as long as the button is held.
                if (!s_btn) begin
                    state_next = REL_DEB;
                    cnt_next   = CNT_ONE;
                end
            end
            default: begin
                state_next = REL_DEB;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: the single DECIDE cycle produces exactly one strobe.
    // Candidates and mode are only looked at here.
    // ------------------------------------------------------------------
    always_comb begin
        valid_next  = 1'b0;
        reject_next = 1'b0;
        cand_next   = vote_candidate;
        if (state == DECIDE) begin
            if (!mode && is_onehot(s_cand)) begin
                valid_next = 1'b1;
                cand_next  = s_cand;
            end else begin
                reject_next = 1'b1;
            end
        end
    end

    // Registered strobes; reset also kills a strobe due on the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vote_valid     <= 1'b0;
            vote_reject    <= 1'b0;
            vote_candidate <= '0;
        end else begin
            vote_valid     <= valid_next;
            vote_reject    <= reject_next;
            vote_candidate <= cand_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ballot_input_conditioner.sv
// Testbench for ballot_input_conditioner with DEBOUNCE_CYCLES = 4.
// Expected strobes are queued when a press is driven and matched by a monitor.
// Timing, candidate hold and busy behaviour are checked against fixed offsets.
module tb_ballot_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       button_raw;
    logic [3:0] candidate_raw;
    logic       mode;
    logic       vote_valid;
    logic [3:0] vote_candidate;
    logic       vote_reject;
    logic       busy;

    ballot_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .button_raw     (button_raw),
        .candidate_raw  (candidate_raw),
        .mode           (mode),
        .vote_valid     (vote_valid),
        .vote_candidate (vote_candidate),
        .vote_reject    (vote_reject),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_valid;
        logic [3:0] cand;
        int         exp_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] model_cand = 4'b0000;
    int         n_pass = 0;
    int         n_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the expected outcome of a press whose button rises right after edge cyc.
    task automatic expect_press(input logic [3:0] cand, input logic md);
        exp_t e;
        e.is_valid = (md == 1'b0) && ($countones(cand) == 1);
        if (e.is_valid) model_cand = cand;
        e.cand    = model_cand;
        e.exp_cyc = cyc + D + 3;
        sb.push_back(e);
    endtask

    task automatic press(input logic [3:0] cand, input logic md, input int hold);
        candidate_raw = cand;
        mode          = md;
        step(1);
        button_raw = 1'b1;
        expect_press(cand, md);
        step(hold);
        button_raw = 1'b0;
        step(D + 8);
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    exp_t got;
    always @(negedge clk) begin
        if (vote_valid || vote_reject) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'({vote_valid, vote_reject}), 32'(0));
            end else begin
                got = sb.pop_front();
                check("strobe_excl", 32'(vote_valid & vote_reject), 32'(0));
                check("strobe_kind", 32'(vote_valid), 32'(got.is_valid));
                check("strobe_cand", 32'(vote_candidate), 32'(got.cand));
                if (got.exp_cyc >= 0) check("strobe_cycle", 32'(cyc), 32'(got.exp_cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int x;

    initial begin
        reset         = 1'b1;
        button_raw    = 1'b0;
        candidate_raw = 4'b0000;
        mode          = 1'b0;

        // Reset values and power-up release debounce.
        step(3);
        check("rst_valid", 32'(vote_valid), 32'(0));
        check("rst_reject", 32'(vote_reject), 32'(0));
        check("rst_cand", 32'(vote_candidate), 32'(0));
        check("rst_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        step(1);
        check("pwr_busy_early", 32'(busy), 32'(1));
        step(D + 1);
        check("pwr_busy_idle", 32'(busy), 32'(0));

        // Clean press, candidate 2, held 20 cycles; strobe after edge D+3.
        press(4'b0010, 1'b0, 20);
        check("clean_sb_empty", 32'(sb.size()), 32'(0));
        check("clean_cand_held", 32'(vote_candidate), 32'(4'b0010));

        // Longest glitch that must still be discarded, then a real press.
        step(1);
        button_raw = 1'b1;
        step(3);
        button_raw = 1'b0;
        step(D + 8);
        check("glitch_busy", 32'(busy), 32'(0));
        press(4'b0100, 1'b0, 10);
        check("glitch_sb_empty", 32'(sb.size()), 32'(0));

        // Candidate changes during PRESS_DEB: the value at DECIDE wins.
        candidate_raw = 4'b0001;
        mode          = 1'b0;
        step(1);
        button_raw = 1'b1;
        expect_press(4'b1000, 1'b0);
        step(4);
        candidate_raw = 4'b1000;
        step(10);
        button_raw = 1'b0;
        step(D + 8);
        check("switch_sb_empty", 32'(sb.size()), 32'(0));

        // Held for 200 cycles, released with 2-cycle bounces.
        candidate_raw = 4'b0001;
        step(1);
        button_raw = 1'b1;
        expect_press(4'b0001, 1'b0);
        step(200);
        check("held_busy", 32'(busy), 32'(1));
        for (int i = 0; i < 2; i++) begin
            button_raw = 1'b0;
            step(2);
            button_raw = 1'b1;
            step(2);
        end
        button_raw = 1'b0;
        x = cyc;
        step(D + 1);
        check("bounce_busy_hi", 32'(busy), 32'(1));
        step(1);
        check("bounce_busy_lo", 32'(busy), 32'(0));
        check("bounce_edge", 32'(cyc), 32'(x + D + 2));
        step(4);
        check("held_sb_empty", 32'(sb.size()), 32'(0));

        // Refused selections leave vote_candidate alone.
        press(4'b0110, 1'b0, 10);
        press(4'b0000, 1'b0, 10);
        press(4'b0001, 1'b1, 10);
        check("reject_sb_empty", 32'(sb.size()), 32'(0));
        check("reject_cand_held", 32'(vote_candidate), 32'(4'b0001));

        // Reset on the edge that would register the strobe suppresses it.
        candidate_raw = 4'b0100;
        mode          = 1'b0;
        step(1);
        button_raw = 1'b1;
        step(D + 2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        model_cand = 4'b0000;
        check("supp_valid", 32'(vote_valid), 32'(0));
        check("supp_cand", 32'(vote_candidate), 32'(0));
        step(5);
        button_raw = 1'b0;
        step(D + 8);
        check("supp_busy", 32'(busy), 32'(0));

        // Reset while in HOLD with the button still down.
        candidate_raw = 4'b0010;
        step(1);
        button_raw = 1'b1;
        expect_press(4'b0010, 1'b0);
        step(D + 8);
        check("hold_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        model_cand = 4'b0000;
        check("hrst_valid", 32'(vote_valid), 32'(0));
        check("hrst_reject", 32'(vote_reject), 32'(0));
        check("hrst_cand", 32'(vote_candidate), 32'(0));
        check("hrst_busy", 32'(busy), 32'(1));
        step(10);
        check("hrst_still_busy", 32'(busy), 32'(1));
        button_raw = 1'b0;
        step(D + 1);
        check("hrst_busy_hi", 32'(busy), 32'(1));
        step(1);
        check("hrst_busy_lo", 32'(busy), 32'(0));
        press(4'b0100, 1'b0, 10);
        check("hrst_cand_new", 32'(vote_candidate), 32'(4'b0100));

        step(5);
        check("final_sb_empty", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
